// File: rtl/cu_microcode_sequencer.sv
// Microcode sequencer: tracks opcode, CB-table mode and micro-step, addresses the microcode ROM
// and steps through it under control of the word's own advance-select and CB-toggle fields.
module cu_microcode_sequencer #(
    parameter int unsigned     CW_W     = 71,
    parameter int unsigned     STEP_W   = 3,
    parameter logic [CW_W-1:0] WE_MASK  = 71'h7E_4000_7180_1000_0000,
    parameter logic [CW_W-1:0] NWE_MASK = 71'h8_0000_0020
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [7:0]        opcode_in,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              mem_wait,
    output logic [8+STEP_W:0] rom_addr,
    input  logic [CW_W-1:0]   rom_data,
    output logic [CW_W-1:0]   control_signals,
    output logic [7:0]        cur_opcode,
    output logic              cb_mode,
    output logic [STEP_W-1:0] step,
    output logic              instr_start,
    output logic              seq_error
);

    localparam logic [1:0] ADV_NEXT  = 2'd0;
    localparam logic [1:0] ADV_FETCH = 2'd1;
    localparam logic [1:0] ADV_COND  = 2'd2;
    localparam logic [1:0] ADV_HOLD  = 2'd3;

    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    logic [7:0]        opcode_q, opcode_d;
    logic              cb_q, cb_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              err_q, err_d;

    logic [1:0] adv;
    logic       tgl;
    logic       cond;
    logic       do_next;
    logic       do_fetch;
    logic       fetch_tgl;

    assign adv = rom_data[34:33];
    assign tgl = rom_data[49];

    // Condition code lives in opcode bits [4:3]: NZ, Z, NC, C.
    always_comb begin
        cond = 1'b0;
        unique case (opcode_q[4:3])
            2'b00: cond = ~flag_z;
            2'b01: cond = flag_z;
            2'b10: cond = ~flag_c;
            2'b11: cond = flag_c;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        opcode_d  = opcode_q;
        cb_d      = cb_q;
        step_d    = step_q;
        err_d     = err_q;
        do_next   = 1'b0;
        do_fetch  = 1'b0;
        fetch_tgl = 1'b0;

        if (!mem_wait) begin
            unique case (adv)
                ADV_NEXT: do_next = 1'b1;
                ADV_FETCH: begin
                    do_fetch  = 1'b1;
                    fetch_tgl = tgl;
                end
                ADV_COND: begin
                    if (cond) do_next = 1'b1;
                    else      do_fetch = 1'b1;
                end
                ADV_HOLD: ;
                default: ;
            endcase
        end

        // Running off the end of the step range is a microcode bug: flag it and refetch.
        if (do_next) begin
            if (step_q == '1) begin
                err_d    = 1'b1;
                do_fetch = 1'b1;
            end else begin
                step_d = step_q + STEP_ONE;
            end
        end

        if (do_fetch) begin
            opcode_d = opcode_in;
            step_d   = '0;
            cb_d     = fetch_tgl ? ~cb_q : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            opcode_q <= 8'h00;
            cb_q     <= 1'b0;
            step_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            opcode_q <= opcode_d;
            cb_q     <= cb_d;
            step_q   <= step_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        control_signals = rom_data;
        if (mem_wait) control_signals = (rom_data & ~WE_MASK) | NWE_MASK;
    end

    assign rom_addr    = {cb_q, opcode_q, step_q};
    assign cur_opcode  = opcode_q;
    assign cb_mode     = cb_q;
    assign step        = step_q;
    assign instr_start = (step_q == '0);
    assign seq_error   = err_q;

endmodule

// File: doc/cu_microcode_sequencer.md
Name: cu_microcode_sequencer

Overview:
- Control-unit sequencer for the Game Boy CPU core.
- Holds the current opcode, CB-prefix mode and micro-step, and from them forms the address into the microcode ROM.
- Presents the ROM word as the 71-bit control word consumed by the control-signal field mapper.
- Uses the mapper's own advance-select and CB-toggle fields, fed back through the word, to decide the next micro-step.

Parameters:
- CW_W, 71: control word width.
- STEP_W, 3: micro-step counter width; max 8 steps per instruction.
- WE_MASK, 71'h7E_4000_7180_1000_0000: bits forced to 0 while stalled (all write-enable fields).
- NWE_MASK, 71'h8_0000_0020: active-low bus strobes forced to 1 while stalled (db_nread bit 35, db_nwrite bit 5).

Ports:
- clk  in  1  core clock.
- nreset  in  1  asynchronous active-low reset.
- opcode_in  in  8  instruction buffer contents, sampled at fetch.
- flag_z  in  1  current Z flag.
- flag_c  in  1  current C flag.
- mem_wait  in  1  bus not ready; freeze sequencer.
- rom_addr  out  9+STEP_W  microcode ROM address {cb_mode, opcode, step}, combinational from state.
- rom_data  in  CW_W  microcode ROM word, combinational from rom_addr.
- control_signals  out  CW_W  control word to the field mapper.
- cur_opcode  out  8  latched opcode.
- cb_mode  out  1  CB-prefixed table active.
- step  out  STEP_W  current micro-step.
- instr_start  out  1  first micro-step of an instruction.
- seq_error  out  1  sticky step-overflow error.

Behaviour:
- Fields decoded internally from rom_data:
  - adv = rom_data[34:33].
  - tgl = rom_data[49].
- Reset (nreset low, async):
  - opcode=8'h00, cb_mode=0, step=0, seq_error=0.
  - instr_start=1.
  - First post-reset cycle executes NOP step 0, whose microcode fetches.
- control_signals:
  - mem_wait=0: equals rom_data; zero added latency.
  - mem_wait=1: (rom_data & ~WE_MASK) | NWE_MASK.
- Stall (mem_wait=1): all state registers hold; adv and tgl ignored.
- adv encoding, evaluated at rising edge when mem_wait=0:
  - 0 NEXT: step<=step+1. If step==all-ones: set seq_error, force a fetch (as adv=1), cb_mode<=0.
  - 1 FETCH: opcode<=opcode_in, step<=0. cb_mode<=tgl ? ~cb_mode : 0.
  - 2 COND: cond is selected by cur_opcode[4:3]: 00 = !Z, 01 = Z, 10 = !C, 11 = C. cond true: as NEXT. cond false: as FETCH with tgl ignored and cb_mode<=0.
  - 3 HOLD: no state change; multi-cycle wait requested by microcode.
- CB prefix:
  - CB-prefix microcode ends with adv=1, tgl=1. The next opcode is then executed from the CB half (cb_mode=1).
  - The CB instruction's own final fetch has tgl=0, which clears cb_mode.
  - tgl with adv=0 or 3 is ignored.
- instr_start = (step==0); combinational.
- seq_error is cleared only by reset.
- Reset asserted mid-instruction: immediate return to reset state. No partial opcode latch.
- Output register values are visible the cycle after the edge; rom_addr is valid the same cycle.
- Internal state is 8+1+STEP_W+1 flops; no other storage.

Test Plan:
- Reset release, ROM[0x000] adv=1, opcode_in=8'h3E → after 1 edge: rom_addr=12'h1F0, cur_opcode=3E, step=0, instr_start=1.
- Opcode 3E with steps 0,1 adv=0 and step 2 adv=1 → step sequence 0,1,2,0; instr_start high on first and last cycle only; new opcode latched at third edge.
- CB: opcode CB step0 adv=1 tgl=1, opcode_in=8'h37 → cb_mode=1, rom_addr=12'h9B8. The following fetch with tgl=0 → cb_mode=0.
- COND: opcode 8'h20 (JR NZ), flag_z=1 at adv=2 → fetch, step=0. With flag_z=0 → step increments.
- mem_wait=1 for 3 cycles at step 1 with rom_data bits 44 and 35 at 1,0 → control_signals bit44=0, bit35=1, state unchanged; normal word returns when mem_wait=0.
- 8 consecutive adv=0 steps → seq_error=1 after 8th edge, step=0, new opcode latched. Async nreset pulse mid-step → all outputs at reset values without a clock edge.
